// File: rtl/adder_rr_scheduler_if.sv
// Request and response channels of the shared-adder scheduler.
// Master drives operands and consumes results; slave is the scheduler itself.
interface adder_rr_scheduler_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
);
    localparam int IDW = $clog2(NREQ);

    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [IDW-1:0]        rsp_id;
    logic [WIDTH-1:0]      rsp_sum;
    logic                  rsp_cout;

    modport master (
        output req_valid, req_a, req_b, req_cin, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );

    modport slave (
        input  req_valid, req_a, req_b, req_cin, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
endinterface

// File: rtl/adder_rr_scheduler.sv
// Round-robin time-sharing of one external combinational adder among NREQ requesters.
//   state  | meaning
//   IDLE   | waiting for a request; grants one per cycle, searching upward from ptr+1
//   ADD    | operand registers drive the shared adder; its result is captured at the edge
//   RESP   | result held on the response channel until rsp_ready
module adder_rr_scheduler #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    adder_rr_scheduler_if.slave bus,
    output logic [WIDTH-1:0]   add_in1,
    output logic [WIDTH-1:0]   add_in2,
    output logic               add_cin,
    input  logic [WIDTH-1:0]   add_sout,
    input  logic               add_cout,
    output logic               busy
);
    localparam int IDW = $clog2(NREQ);

    typedef enum logic [1:0] {S_IDLE, S_ADD, S_RESP} state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             op_cin;
    logic [IDW-1:0]   id_q;
    logic [WIDTH-1:0] sum_q;
    logic             cout_q;
    logic             rsp_valid_q;
    logic             grant_vld;
    logic [IDW-1:0]   grant_idx;

    // Cyclic priority search: the first hit starting just after the last winner.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        for (int k = 1; k <= NREQ; k++) begin
            if (!grant_vld && bus.req_valid[IDW'((int'(ptr) + k) % NREQ)]) begin
                grant_vld = 1'b1;
                grant_idx = IDW'((int'(ptr) + k) % NREQ);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            ptr         <= IDW'(NREQ - 1);
            op_a        <= '0;
            op_b        <= '0;
            op_cin      <= 1'b0;
            id_q        <= '0;
            sum_q       <= '0;
            cout_q      <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (grant_vld) begin
                        op_a   <= bus.req_a[grant_idx*WIDTH +: WIDTH];
                        op_b   <= bus.req_b[grant_idx*WIDTH +: WIDTH];
                        op_cin <= bus.req_cin[grant_idx];
                        id_q   <= grant_idx;
                        ptr    <= grant_idx;
                        state  <= S_ADD;
                    end
                end
                S_ADD: begin
                    sum_q       <= add_sout;
                    cout_q      <= add_cout;
                    rsp_valid_q <= 1'b1;
                    state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state       <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Strobe depends only on registered state and req_valid, never on rsp_ready.
    assign bus.req_ready = (state == S_IDLE && grant_vld) ? (NREQ'(1) << grant_idx) : '0;

    assign add_in1       = op_a;
    assign add_in2       = op_b;
    assign add_cin       = op_cin;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = id_q;
    assign bus.rsp_sum   = sum_q;
    assign bus.rsp_cout  = cout_q;
    assign busy          = (state != S_IDLE);
endmodule

// File: tb/tb_adder_rr_scheduler.sv
// Directed bench for adder_rr_scheduler with a behavioural 32-bit adder.
module tb_adder_rr_scheduler;
    localparam int NREQ  = 4;
    localparam int WIDTH = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic [WIDTH-1:0] add_in1, add_in2, add_sout;
    logic             add_cin, add_cout, busy;

    int n_pass  = 0;
    int n_total = 0;

    adder_rr_scheduler_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    adder_rr_scheduler #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .add_in1  (add_in1),
        .add_in2  (add_in2),
        .add_cin  (add_cin),
        .add_sout (add_sout),
        .add_cout (add_cout),
        .busy     (busy)
    );

    assign {add_cout, add_sout} = {1'b0, add_in1} + {1'b0, add_in2} + {32'd0, add_cin};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int id, input logic [31:0] a, input logic [31:0] b, input logic c);
        bus.req_a[id*WIDTH +: WIDTH] = a;
        bus.req_b[id*WIDTH +: WIDTH] = b;
        bus.req_cin[id]              = c;
    endtask

    // Lone request from an idle scheduler through to its consumed response.
    task automatic single(input int id, input logic [31:0] a, input logic [31:0] b, input logic c,
                          input logic [31:0] exp_sum, input logic exp_cout);
        set_req(id, a, b, c);
        bus.req_valid = 4'b0001 << id;
        #1;
        chk("single_ready", 64'(bus.req_ready), 64'(4'b0001 << id));
        step();
        bus.req_valid = '0;
        chk("single_ready_off", 64'(bus.req_ready), 64'd0);
        chk("single_busy", 64'(busy), 64'd1);
        chk("single_in1", 64'(add_in1), 64'(a));
        chk("single_valid_lo", 64'(bus.rsp_valid), 64'd0);
        step();
        chk("single_valid", 64'(bus.rsp_valid), 64'd1);
        chk("single_id", 64'(bus.rsp_id), 64'(id));
        chk("single_sum", 64'(bus.rsp_sum), 64'(exp_sum));
        chk("single_cout", 64'(bus.rsp_cout), 64'(exp_cout));
        bus.rsp_ready = 1'b1;
        step();
        bus.rsp_ready = 1'b0;
        chk("single_done_valid", 64'(bus.rsp_valid), 64'd0);
        chk("single_done_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int exp_gnt [6] = '{0, 1, 2, 3, 0, 1};
        logic [31:0] exp_sum [4] = '{32'd1, 32'd102, 32'd203, 32'd304};
        int n_acc;
        int n_rsp;

        rst           = 1'b1;
        bus.req_valid = '0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = '0;
        bus.rsp_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
        #1;
        chk("rst_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_ready", 64'(bus.req_ready), 64'd0);
        chk("rst_in1", 64'(add_in1), 64'd0);
        chk("rst_cin", 64'(add_cin), 64'd0);
        chk("rst_id", 64'(bus.rsp_id), 64'd0);
        chk("rst_sum", 64'(bus.rsp_sum), 64'd0);

        single(2, 32'd1000, 32'd1010, 1'b0, 32'd2010, 1'b0);
        single(0, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1);
        single(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 32'hFFFF_FFFF, 1'b1);
        single(3, 32'd1000000, 32'd1000010, 1'b1, 32'd2000011, 1'b0);

        // Fairness: ptr is 3, so all-valid starts at 0.
        for (int i = 0; i < NREQ; i++) set_req(i, 32'(i * 100 + 1), 32'(i), 1'b0);
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        n_acc = 0;
        n_rsp = 0;
        #1;
        for (int cyc = 0; cyc < 18; cyc++) begin
            if (bus.req_ready != '0) begin
                if (n_acc < 6) begin
                    chk("fair_grant", 64'(bus.req_ready), 64'(4'b0001 << exp_gnt[n_acc]));
                    chk("fair_spacing", 64'(cyc), 64'(3 * n_acc));
                end
                n_acc++;
            end
            if (bus.rsp_valid) begin
                if (n_rsp < 6) begin
                    chk("fair_rsp_id", 64'(bus.rsp_id), 64'(exp_gnt[n_rsp]));
                    chk("fair_rsp_sum", 64'(bus.rsp_sum), 64'(exp_sum[exp_gnt[n_rsp]]));
                end
                n_rsp++;
            end
            if (cyc == 17) bus.req_valid = '0;
            step();
            #1;
        end
        chk("fair_accepts", 64'(n_acc), 64'd6);
        chk("fair_responses", 64'(n_rsp), 64'd6);
        bus.rsp_ready = 1'b0;
        chk("fair_idle", 64'(busy), 64'd0);

        // Backpressure with requester 3 (ptr is 1); requester 0 knocks while busy.
        set_req(3, 32'd7, 32'd8, 1'b1);
        bus.req_valid = 4'b1000;
        #1;
        chk("bp_ready", 64'(bus.req_ready), 64'b1000);
        step();
        bus.req_valid = 4'b0001;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 64'(bus.rsp_valid), 64'd1);
            chk("bp_sum", 64'(bus.rsp_sum), 64'd16);
            chk("bp_id", 64'(bus.rsp_id), 64'd3);
            chk("bp_ready_lo", 64'(bus.req_ready), 64'd0);
            chk("bp_busy", 64'(busy), 64'd1);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_release_valid", 64'(bus.rsp_valid), 64'd0);
        chk("bp_release_busy", 64'(busy), 64'd0);
        chk("bp_waiting_grant", 64'(bus.req_ready), 64'b0001);
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        step();
        chk("bp_dropped", 64'(busy), 64'd0);

        // Reset while in ADD discards the request.
        set_req(2, 32'd5, 32'd6, 1'b0);
        bus.req_valid = 4'b0100;
        step();
        bus.req_valid = '0;
        chk("mid_in_add", 64'(busy), 64'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_busy", 64'(busy), 64'd0);
        chk("mid_in1", 64'(add_in1), 64'd0);
        step();
        chk("mid_no_rsp", 64'(bus.rsp_valid), 64'd0);

        set_req(0, 32'd11, 32'd22, 1'b0);
        set_req(3, 32'd40, 32'd2, 1'b0);
        bus.req_valid = 4'b1001;
        #1;
        chk("post_rst_first", 64'(bus.req_ready), 64'b0001);
        step();
        bus.req_valid = 4'b1000;
        step();
        chk("post_rst_id0", 64'(bus.rsp_id), 64'd0);
        chk("post_rst_sum0", 64'(bus.rsp_sum), 64'd33);
        bus.rsp_ready = 1'b1;
        step();
        chk("post_rst_second", 64'(bus.req_ready), 64'b1000);
        step();
        bus.req_valid = '0;
        step();
        chk("post_rst_id3", 64'(bus.rsp_id), 64'd3);
        chk("post_rst_sum3", 64'(bus.rsp_sum), 64'd42);
        step();
        chk("post_rst_idle", 64'(busy), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/adder_rr_scheduler.md
Name: adder_rr_scheduler

Overview:
Time-shares one 32-bit unsigned adder among NREQ requesters. Each requester presents operands and a carry-in with a valid/ready handshake. A round-robin arbiter grants one requester at a time. The block drives the shared combinational adder (in1/in2/cin in, sout/cout out), registers its result and returns it with the requester ID on a valid/ready response channel.

Parameters:
NREQ, 4, number of requesters (2..8)
WIDTH, 32, operand/sum width
IDW, $clog2(NREQ), requester ID width (derived, localparam)

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  NREQ  per-requester operand valid
req_ready  output  NREQ  per-requester accept strobe (one-hot or zero)
req_a  input  NREQ*WIDTH  packed operand A, requester i at [i*WIDTH +: WIDTH]
req_b  input  NREQ*WIDTH  packed operand B, same packing
req_cin  input  NREQ  per-requester carry-in
add_in1  output  WIDTH  to shared adder in1
add_in2  output  WIDTH  to shared adder in2
add_cin  output  1  to shared adder cin
add_sout  input  WIDTH  from shared adder sum
add_cout  input  1  from shared adder carry-out
rsp_valid  output  1  result valid
rsp_ready  input  1  consumer accepts result
rsp_id  output  IDW  requester index of the result
rsp_sum  output  WIDTH  registered sum
rsp_cout  output  1  registered carry-out
busy  output  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock (clk). Reset (rst) is synchronous and active-high. Reset takes priority over every other event.
- FSM states: IDLE, ADD, RESP.
- IDLE:
  - If any req_valid bit is set, grant index g = first set bit searching upward (cyclically) from ptr+1.
  - req_ready[g]=1 combinationally in this cycle only.
  - On the clock edge, latch req_a[g], req_b[g] and req_cin[g] into operand registers, latch g into id register, set ptr<=g, and go to ADD.
  - With no request, stay in IDLE with req_ready=0.
- ADD:
  - add_in1, add_in2 and add_cin are driven from the operand registers; they are driven from those registers in every state.
  - On the clock edge, capture rsp_sum<=add_sout and rsp_cout<=add_cout, set rsp_valid<=1, and go to RESP.
- RESP:
  - rsp_valid=1. rsp_id, rsp_sum and rsp_cout are held stable.
  - When rsp_valid&&rsp_ready: rsp_valid<=0 and go to IDLE.
  - Otherwise hold indefinitely (backpressure). req_ready=0 throughout ADD and RESP.
- Latency and throughput:
  - Request accepted at edge T gives rsp_valid=1 after edge T+1.
  - Minimum spacing between accepts is 3 cycles (IDLE→ADD→RESP→IDLE).
  - No combinational path from rsp_ready to req_ready.
- Arithmetic: result equals {cout,sum} = a+b+cin, 33-bit exact. Wrap-around is reported through cout only; no saturation.
- Reset values:
  - state=IDLE; ptr=NREQ-1, so requester 0 wins first.
  - Operand registers=0, therefore add_in1/add_in2/add_cin=0.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, req_ready=0, busy=0.
- Reset mid-operation: an in-flight request in ADD or RESP is discarded with no response. Requesters must re-present.
- Simultaneous requests: exactly one grant per IDLE cycle. Ungranted requesters keep req_valid high and are served in cyclic order after ptr.
- A requester dropping req_valid before grant is legal and simply loses its slot.
- req_valid asserted while busy is ignored until IDLE.

Test Plan:
- Single request, the bench instantiates a behavioural 32-bit adder. Requester 2 presents a=1000, b=1010, cin=0. Expect req_ready=4'b0100 for one cycle, then 2 cycles later rsp_valid=1, rsp_id=2, rsp_sum=2010, rsp_cout=0.
- Overflow corners:
  - 0xFFFFFFFF+0x00000001, cin=0 → sum=0x00000000, cout=1.
  - 0xFFFFFFFF+0xFFFFFFFF, cin=1 → sum=0xFFFFFFFF, cout=1.
  - 1000000+1000010, cin=1 → sum=2000011, cout=0.
- Fairness: all 4 req_valid held high, rsp_ready=1. Grant order 0,1,2,3,0,1 with accepts exactly 3 cycles apart, and each rsp_id matches its grant.
- Backpressure: rsp_ready=0 for 5 cycles after rsp_valid rises. rsp_valid, rsp_sum and rsp_id stay stable, req_ready stays 0 and busy=1. rsp_ready=1 gives return to IDLE next cycle.
- Reset mid-op: assert rst for 1 cycle while in ADD.
  - Next cycle: rsp_valid=0, busy=0, add_in1=0.
  - Requesters 3 and 0 then request together → 0 granted first, then 3.
